// File: rtl/bnn_fc_engine_pkg.sv
// Shared types and helpers for the binary fully-connected engine.
// State encoding, output-mode constants and result-width function.
package bnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic MODE_RAW  = 1'b0;
  localparam logic MODE_SIGN = 1'b1;

  // Width holding 0 .. in_dim*(2^ch_cnt-1)
  function automatic int acc_width(input int in_dim, input int ch_cnt);
    return $clog2(in_dim * ((1 << ch_cnt) - 1) + 1);
  endfunction

endpackage

// File: rtl/bnn_fc_engine_if.sv
// Frame-in / result-out handshake bundle of the BNN engine.
// master = frame producer and result consumer, slave = engine.
interface bnn_fc_engine_if
  import bnn_pkg::*;
#(
  parameter int IN_DIM    = 64,
  parameter int OUT_DIM   = 16,
  parameter int BIT_WIDTH = 8,
  parameter int CH_CNT    = 4,
  parameter int ACC_W     = acc_width(IN_DIM, CH_CNT)
);

  logic                              in_valid;
  logic                              in_ready;
  logic [IN_DIM-1:0][BIT_WIDTH-1:0]  value_in;
  logic                              out_mode;
  logic [OUT_DIM-1:0][IN_DIM-1:0]    weight;
  logic                              out_valid;
  logic                              out_ready;
  logic [OUT_DIM-1:0][ACC_W-1:0]     value_out;
  logic                              busy;

  modport master (
    output in_valid, value_in, out_mode, weight, out_ready,
    input  in_ready, out_valid, value_out, busy
  );

  modport slave (
    input  in_valid, value_in, out_mode, weight, out_ready,
    output in_ready, out_valid, value_out, busy
  );

endinterface

// File: rtl/bnn_fc_engine_xnor_popcount.sv
// XNOR of two N-bit vectors followed by a balanced adder-tree popcount.
// Leaves are padded to a power of two with zeros.
module bnn_xnor_popcount #(
  parameter int N  = 64,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]  i_a,
  input  logic [N-1:0]  i_b,
  output logic [OW-1:0] o_cnt
);

  localparam int L = (N > 1) ? $clog2(N) : 0;
  localparam int P = 1 << L;

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    logic [OW-1:0] w_s [P >> l];
    for (genvar j = 0; j < (P >> l); j++) begin : g_n
      if (l == 0) begin : g_leaf
        if (j < N) begin : g_bit
          assign w_s[j] = OW'(~(i_a[j] ^ i_b[j]));
        end else begin : g_pad
          assign w_s[j] = '0;
        end
      end else begin : g_add
        assign w_s[j] = g_lvl[l-1].w_s[2*j] + g_lvl[l-1].w_s[2*j+1];
      end
    end
  end

  assign o_cnt = g_lvl[L].w_s[0];

endmodule

// File: rtl/bnn_fc_engine.sv
// Folded binary FC layer: bit-plane weighted XNOR-popcount,
// PAR neurons per cycle, raw or sign output, valid/ready framed.
module bnn_fc_engine
  import bnn_pkg::*;
#(
  parameter  int IN_DIM    = 64,
  parameter  int OUT_DIM   = 16,
  parameter  int BIT_WIDTH = 8,
  parameter  int CH_CNT    = 4,
  parameter  int PAR       = 4,
  localparam int ACC_W     = acc_width(IN_DIM, CH_CNT)
) (
  input logic         clk,
  input logic         rst,
  bnn_fc_engine_if.slave bus
);

  localparam int NG = OUT_DIM / PAR;
  localparam int PW = $clog2(IN_DIM + 1);
  localparam int CW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int NW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int BW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

  localparam logic [CW-1:0] CH_LAST  = CW'(CH_CNT - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NG - 1);
  localparam logic [ACC_W:0] LIM =
    (ACC_W+1)'(IN_DIM * ((1 << CH_CNT) - 1));

  if (CH_CNT > BIT_WIDTH) begin : g_chk_ch
    $error("CH_CNT must not exceed BIT_WIDTH");
  end
  if (OUT_DIM % PAR != 0) begin : g_chk_par
    $error("OUT_DIM must be a multiple of PAR");
  end

  state_t                           r_state;
  logic                             r_in_ready;
  logic                             r_out_valid;
  logic                             r_busy;
  logic                             r_mode;
  logic [IN_DIM-1:0][BIT_WIDTH-1:0] r_pix;
  logic [CW-1:0]                    r_ch;
  logic [GW-1:0]                    r_grp;
  logic [ACC_W-1:0]                 r_acc [PAR];
  logic [OUT_DIM-1:0][ACC_W-1:0]    r_out;

  logic                             w_accept;
  logic [BW-1:0]                    w_bit;
  logic [CW-1:0]                    w_sh;
  logic [IN_DIM-1:0]                w_plane;
  logic [NW-1:0]                    w_idx [PAR];
  logic [PW-1:0]                    w_pop [PAR];
  logic [ACC_W-1:0]                 w_sum [PAR];
  logic [ACC_W-1:0]                 w_res [PAR];

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_bit    = BW'(BIT_WIDTH - 1) - BW'(r_ch);
  assign w_sh     = CH_LAST - r_ch;

  // Current bit-plane of the latched frame, MSB plane first
  always_comb begin
    w_plane = '0;
    for (int i = 0; i < IN_DIM; i++) begin
      w_plane[i] = r_pix[i][w_bit];
    end
  end

  for (genvar k = 0; k < PAR; k++) begin : g_lane
    assign w_idx[k] = NW'(int'(r_grp) * PAR + k);

    bnn_xnor_popcount #(.N(IN_DIM), .OW(PW)) u_pc (
      .i_a   (bus.weight[w_idx[k]]),
      .i_b   (w_plane),
      .o_cnt (w_pop[k])
    );

    assign w_sum[k] = r_acc[k] + (ACC_W'(w_pop[k]) << w_sh);
    assign w_res[k] = (r_mode == MODE_SIGN)
                    ? ACC_W'({w_sum[k], 1'b0} >= LIM)
                    : w_sum[k];
  end

  // Frame FSM: accept, fold planes/groups, hold results until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_mode      <= MODE_RAW;
      r_pix       <= '0;
      r_ch        <= '0;
      r_grp       <= '0;
      r_out       <= '0;
      for (int k = 0; k < PAR; k++) r_acc[k] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pix      <= bus.value_in;
            r_mode     <= bus.out_mode;
            r_ch       <= '0;
            r_grp      <= '0;
            for (int k = 0; k < PAR; k++) r_acc[k] <= '0;
            r_state    <= S_COMPUTE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_COMPUTE: begin
          for (int k = 0; k < PAR; k++) begin
            if (r_ch == CH_LAST) begin
              r_out[w_idx[k]] <= w_res[k];
              r_acc[k]        <= '0;
            end else begin
              r_acc[k] <= w_sum[k];
            end
          end
          if (r_ch == CH_LAST) begin
            r_ch <= '0;
            if (r_grp == GRP_LAST) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_grp <= r_grp + 1'b1;
            end
          end else begin
            r_ch <= r_ch + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.value_out = r_out;

endmodule

// File: tb/tb_bnn_fc_engine.sv
// Directed bench for bnn_fc_engine with an arithmetic reference model.
// Frames, backpressure and mid-compute reset.
module tb_bnn_fc_engine;
  import bnn_pkg::*;

  localparam int IN_DIM    = 64;
  localparam int OUT_DIM   = 16;
  localparam int BIT_WIDTH = 8;
  localparam int CH_CNT    = 4;
  localparam int PAR       = 4;
  localparam int ACC_W     = acc_width(IN_DIM, CH_CNT);
  localparam int LAT       = (OUT_DIM / PAR) * CH_CNT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bnn_fc_engine_if #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM),
    .BIT_WIDTH(BIT_WIDTH), .CH_CNT(CH_CNT)
  ) bus ();

  bnn_fc_engine #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .BIT_WIDTH(BIT_WIDTH),
    .CH_CNT(CH_CNT), .PAR(PAR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int pix [IN_DIM];
  bit wt  [OUT_DIM][IN_DIM];
  bit mode;
  int exp_v [OUT_DIM];
  bit armed = 1'b0;

  int cmp_bad;
  int cmp_n;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int model(input int n);
    int acc = 0;
    for (int c = 0; c < CH_CNT; c++) begin
      int pop = 0;
      for (int i = 0; i < IN_DIM; i++) begin
        if (((pix[i] >> (BIT_WIDTH - 1 - c)) & 1) == int'(wt[n][i]))
          pop++;
      end
      acc += pop * (1 << (CH_CNT - 1 - c));
    end
    if (mode)
      acc = (2 * acc >= IN_DIM * ((1 << CH_CNT) - 1)) ? 1 : 0;
    return acc;
  endfunction

  task automatic set_pix_const(input int v);
    for (int i = 0; i < IN_DIM; i++) pix[i] = v;
  endtask

  task automatic set_pix_ramp();
    for (int i = 0; i < IN_DIM; i++) pix[i] = (i * 37 + 11) & 255;
  endtask

  // kind: 0 all -1, 1 all +1, 2 first half +1, 3 mixed pattern
  task automatic set_wt(input int kind);
    for (int n = 0; n < OUT_DIM; n++)
      for (int i = 0; i < IN_DIM; i++)
        case (kind)
          0: wt[n][i] = 1'b0;
          1: wt[n][i] = 1'b1;
          2: wt[n][i] = (i < IN_DIM / 2);
          default: wt[n][i] = (((i * 7 + n * 3) % 5) < 2);
        endcase
  endtask

  // Every cycle results are offered: compare against the model
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1) begin
      checks++;
      cmp_bad = 0;
      cmp_n   = -1;
      if (!armed) cmp_bad = 1;
      for (int n = 0; n < OUT_DIM; n++) begin
        if (bus.value_out[n] !== ACC_W'(exp_v[n])) begin
          if (cmp_n < 0) cmp_n = n;
          cmp_bad = 1;
        end
      end
      if (bus.in_ready !== 1'b0) cmp_bad = 1;
      if (cmp_bad != 0) begin
        failures++;
        if (cmp_n >= 0)
          $display("FAIL result slot%0d actual=%0d required=%0d",
                   cmp_n, bus.value_out[cmp_n], exp_v[cmp_n]);
        else
          $display("FAIL result_state armed=%0d in_ready=%0d",
                   armed, bus.in_ready);
      end
    end
  end

  // Present the frame, let it be accepted at the next edge
  task automatic start_frame(input bit m, input bit keep);
    mode = m;
    for (int i = 0; i < IN_DIM; i++)
      bus.value_in[i] = BIT_WIDTH'(pix[i]);
    for (int n = 0; n < OUT_DIM; n++)
      for (int i = 0; i < IN_DIM; i++)
        bus.weight[n][i] = wt[n][i];
    bus.out_mode = m;
    for (int n = 0; n < OUT_DIM; n++) exp_v[n] = model(n);
    bus.in_valid = 1'b1;
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    armed = 1'b1;
    if (!keep) bus.in_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1);
    check("in_ready_after_accept", bus.in_ready, 0);
  endtask

  task automatic wait_valid(input int lit);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < LAT + 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, LAT);
    if (lit >= 0) begin
      check("lit_slot0", bus.value_out[0], lit);
      check("lit_slot_last", bus.value_out[OUT_DIM-1], lit);
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    armed = 1'b0;
    check("out_valid_after_hs", bus.out_valid, 0);
    check("in_ready_after_hs", bus.in_ready, 1);
  endtask

  task automatic frame(input bit m, input int lit);
    start_frame(m, 1'b0);
    wait_valid(lit);
    handshake();
  endtask

  int nz;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.out_mode  = 1'b0;
    bus.value_in  = '0;
    bus.weight    = '0;

    // Reset state, handshake attempts during reset ignored
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    nz = 0;
    for (int n = 0; n < OUT_DIM; n++) if (bus.value_out[n] != 0) nz++;
    check("rst_value_out_nonzero", nz, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", bus.busy, 0);

    set_pix_const(8'hFF); set_wt(1); frame(1'b0, 960);
    set_pix_const(8'hFF); set_wt(0); frame(1'b0, 0);
    frame(1'b1, 0);
    set_pix_const(8'h80); set_wt(1); frame(1'b0, 512);
    frame(1'b1, 1);
    set_pix_const(8'h80); set_wt(2); frame(1'b0, 480);
    frame(1'b1, 1);
    set_pix_ramp(); set_wt(3); frame(1'b0, -1);
    frame(1'b1, -1);

    // Backpressure with in_valid held high throughout
    set_pix_const(8'hFF); set_wt(1);
    start_frame(1'b0, 1'b1);
    wait_valid(960);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
    end
    handshake();
    check("bp_idle_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    armed = 1'b1;
    check("bp_reaccept_busy", bus.busy, 1);
    check("bp_reaccept_in_ready", bus.in_ready, 0);
    wait_valid(960);
    handshake();

    // Reset in the middle of a computation
    set_pix_ramp(); set_wt(3);
    start_frame(1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    armed = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_busy", bus.busy, 0);
    nz = 0;
    for (int n = 0; n < OUT_DIM; n++) if (bus.value_out[n] != 0) nz++;
    check("mid_rst_value_out_nonzero", nz, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_pix_const(8'hFF); set_wt(1);
    frame(1'b0, 960);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bnn_fc_engine.md
# bnn_fc_engine

Sequential, parametrised binary fully-connected layer engine. Accepts one frame of unsigned pixels over a valid/ready handshake and splits each pixel into its top CH_CNT bit-planes. It then computes, for every output neuron, a bit-plane-weighted XNOR-popcount against a ±1 weight row, time-multiplexing PAR neurons per cycle. It replaces the single-cycle combinational binarize/XNOR/accumulate layer and adds handshaking, neuron folding and a sign-output mode.

## Interface
- IN_DIM, 64, inputs per frame
- OUT_DIM, 16, output neurons
- BIT_WIDTH, 8, pixel width
- CH_CNT, 4, bit-planes used (MSB first); elaboration error if CH_CNT > BIT_WIDTH
- PAR, 4, neurons evaluated per cycle; elaboration error if OUT_DIM % PAR != 0
- ACC_W (derived), clog2(IN_DIM*(2^CH_CNT-1)+1), result width (10 at defaults)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  frame valid
- in_ready  out  1  engine idle, frame accepted on in_valid&in_ready
- value_in  in  [IN_DIM][BIT_WIDTH]  unsigned pixels
- out_mode  in  1  0 = raw accumulation, 1 = sign bit; sampled at accept
- weight  in  [OUT_DIM][IN_DIM]  1 = +1, 0 = -1; must be stable from accept until out_valid
- out_valid  out  1  results valid
- out_ready  in  1  consumer accepts results
- value_out  out  [OUT_DIM][ACC_W]  results, registered
- busy  out  1  state != IDLE

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register value_in and out_mode, clear counters and accumulators, go to COMPUTE.
- Plane c (0..CH_CNT-1) of input i = bit (BIT_WIDTH-1-c) of pixel i.
- COMPUTE:
  - Counters ch (0..CH_CNT-1, inner) and grp (0..OUT_DIM/PAR-1, outer).
  - Each cycle, for neuron n = grp*PAR+k (k<PAR): acc[k] += popcount(weight[n] XNOR plane_ch) << (CH_CNT-1-ch).
  - When ch = CH_CNT-1, write the final acc[k] to value_out[n] and clear acc.
  - Last grp and last ch: go to DONE.
- Result per neuron is sum over c of pop_c·2^(CH_CNT-1-c). The range is 0..IN_DIM·(2^CH_CNT-1), so there is no overflow at ACC_W.
- out_mode=1: value_out[n] = zero-extended (2·acc >= IN_DIM·(2^CH_CNT-1)). The comparison is done in integer form, with no rounding; equality gives 1.
- DONE:
  - out_valid=1; value_out held stable.
  - On out_valid&out_ready: go to IDLE.
- in_valid is ignored outside IDLE. Frames never overlap.

## Timing
- Reset values:
  - State IDLE; in_ready=1, out_valid=0, busy=0.
  - value_out all 0; counters and accumulators 0.
- Handshakes while rst is high are ignored.
- Latency: the accept edge is E. out_valid rises at edge E + (OUT_DIM/PAR)·CH_CNT (16 at defaults). in_ready falls at E.
- out_valid is held indefinitely under out_ready=0.
- The output handshake edge H clears out_valid. in_ready=1 from H. Earliest next accept is at edge H+1.
- Reset mid-COMPUTE or in DONE: immediate return to reset values, with no partial results visible. The first frame after reset completes normally.
- value_out slots change only during COMPUTE, never in DONE or IDLE.

## Structure
- bnn_pkg:
  - state enum.
  - acc_width(in_dim, ch_cnt) function.
  - out_mode constants (MODE_RAW=0, MODE_SIGN=1).
- Sub-module bnn_xnor_popcount #(N=IN_DIM): combinational XNOR of two N-bit vectors plus an adder-tree popcount, output clog2(N+1) bits. Instantiated PAR times.

## Test plan
- All pixels 0xFF, all weights 1, mode 0 → every value_out = 960; out_valid exactly 16 cycles after accept.
- All pixels 0xFF, all weights 0, mode 0 → all 0; repeat with mode 1 → all 0.
- All pixels 0x80, all weights 1, mode 0 → 512; mode 1 → 1 (1024 ≥ 960).
- All pixels 0x80, weights 32 ones/32 zeros → raw 480; mode 1 → 1 (equality boundary 960 ≥ 960).
- out_ready low 10 cycles after out_valid, in_valid held high → value_out stable, in_ready 0, no second accept; after handshake, new frame accepted one cycle later.
- rst pulsed at cycle 7 of COMPUTE → out_valid 0, value_out 0, in_ready 1; next frame (0xFF/all-ones) yields 960 with 16-cycle latency.
